// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter sharing the single-port RAM between two requesters.
// Turns each grant into the RAM's 2-beat command stream and returns data/ack to the owner.
module ram_req_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic                 samp_clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata0,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic [1:0]           ack,
  output logic [ADDR_SIZE-1:0] rdata,
  output logic                 err,
  output logic                 busy,
  output logic                 ram_rx_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  input  logic                 ram_tx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout
);

  localparam int unsigned DIN_W = ADDR_SIZE + 2;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_CMD  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic                 win_q, win_d;
  logic                 rr_q, rr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [ADDR_SIZE-1:0] last_wr_q, last_wr_d;
  logic [ADDR_SIZE-1:0] last_rd_q, last_rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           ack_q, ack_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 rx_q, rx_d;
  logic [DIN_W-1:0]     din_q, din_d;

  logic                 win_c;
  logic [ADDR_SIZE-1:0] addr_sel_c;
  logic [ADDR_SIZE-1:0] wdata_sel_c;
  logic [ADDR_SIZE-1:0] res_rdata_c;
  logic                 res_err_c;

  // State register and all registered outputs
  always_ff @(posedge samp_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      rr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      last_wr_q <= '0;
      last_rd_q <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rx_q      <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_vld_q  <= wr_vld_d;
      rd_vld_q  <= rd_vld_d;
      last_wr_q <= last_wr_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rx_q      <= rx_d;
      din_q     <= din_d;
    end
  end

  // Next state, grant/cache bookkeeping, and outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_vld_d    = wr_vld_q;
    rd_vld_d    = rd_vld_q;
    last_wr_d   = last_wr_q;
    last_rd_d   = last_rd_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rdata_d     = '0;
    err_d       = 1'b0;
    busy_d      = 1'b0;
    rx_d        = 1'b0;
    din_d       = '0;
    win_c       = (req == 2'b11) ? rr_q : req[1];
    addr_sel_c  = win_c ? addr1 : addr0;
    wdata_sel_c = win_c ? wdata1 : wdata0;
    res_rdata_c = '0;
    res_err_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = win_c;
          rr_d    = ~win_c;
          addr_d  = addr_sel_c;
          wdata_d = wdata_sel_c;
          // Skip the address beat when the RAM already holds this address
          if (we[win_c]) begin
            state_d = (!wr_vld_q || addr_sel_c != last_wr_q) ? S_WR_ADDR : S_WR_DATA;
          end else begin
            state_d = (!rd_vld_q || addr_sel_c != last_rd_q) ? S_RD_ADDR : S_RD_CMD;
          end
        end
      end
      S_WR_ADDR: begin
        wr_vld_d  = 1'b1;
        last_wr_d = addr_q;
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: state_d = S_RESP;
      S_RD_ADDR: begin
        rd_vld_d  = 1'b1;
        last_rd_d = addr_q;
        state_d   = S_RD_CMD;
      end
      S_RD_CMD: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ram_tx_valid) begin
          res_rdata_c = ram_dout;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_err_c = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_WR_ADDR: begin
        rx_d  = 1'b1;
        din_d = {2'b00, addr_d};
      end
      S_WR_DATA: begin
        rx_d  = 1'b1;
        din_d = {2'b01, wdata_d};
      end
      S_RD_ADDR: begin
        rx_d  = 1'b1;
        din_d = {2'b10, addr_d};
      end
      S_RD_CMD: begin
        rx_d  = 1'b1;
        din_d = {2'b11, {ADDR_SIZE{1'b0}}};
      end
      S_RESP: begin
        ack_d[win_d] = 1'b1;
        rdata_d      = res_rdata_c;
        err_d        = res_err_c;
      end
      default: ;
    endcase
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign ram_rx_valid = rx_q;
  assign ram_din      = din_q;

endmodule
